pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Owns the program counter register and drives instruction fetch. Each cycle it takes
//  either PC+1 or a jump target, requests the instruction at PC from instruction memory,
//  and buffers the returned words in a small FIFO until the decoder accepts them.
//  Sits between the instruction memory port and the decode stage.
// PARAMETERS
//  ADDR_W    8   PC / instruction-memory address width; PC wraps modulo 2**ADDR_W
//  INSTR_W   16  instruction word width
//  TGT_W     5   jump target width; zero-extended to ADDR_W
//  BUF_DEPTH 2   instruction buffer entries (power of two, >=2)
//  RESET_PC  0   PC value after reset
// PORTS
//  clk           in   1        clock, rising edge
//  rst_n         in   1        asynchronous active-low reset
//  halt_i        in   1        stop issuing new fetches while high
//  jump_i        in   1        redirect PC this cycle
//  jump_tgt_i    in   TGT_W    jump target (zero-extended)
//  imem_req_o    out  1        fetch request
//  imem_addr_o   out  ADDR_W   fetch address (= PC)
//  imem_gnt_i    in   1        request accepted this cycle
//  imem_rvalid_i in   1        read data valid (>=1 cycle after gnt)
//  imem_rdata_i  in   INSTR_W  read data
//  instr_valid_o out  1        buffer head valid
//  instr_o       out  INSTR_W  buffer head instruction
//  instr_pc_o    out  ADDR_W   address the head instruction was fetched from
//  instr_ready_i in   1        decoder accepts head (pop when valid & ready)
//  pc_o          out  ADDR_W   current PC register
// BEHAVIOUR
//  Reset (async, rst_n=0): pc_o=RESET_PC; imem_req_o=0; instr_valid_o=0; instr_o=0;
//   instr_pc_o=0; buffer empty; no outstanding request; state IDLE.
//  FSM: IDLE -> FETCH on the first clock after reset release.
//   FETCH: imem_req_o=1 iff entries+outstanding < BUF_DEPTH, else 0 (stay FETCH).
//    gnt while req -> WAIT; pc <= pc+1 (wraps 2**ADDR_W-1 -> 0).
//   WAIT: req=0; exactly one outstanding request. rvalid -> push {addr, rdata},
//    -> FETCH (or HALTED if halt_i). Data available at instr_o the next cycle.
//   HALTED: entered from FETCH when halt_i=1 and no gnt that cycle; req=0;
//    leaves to FETCH the cycle after halt_i=0. halt_i in WAIT: finish response first.
//  imem_addr_o = pc_o; held stable while req=1 and gnt=0 unless a jump occurs.
//  Jump (any state): pc <= zero-extended jump_tgt_i; buffer flushed same edge;
//   instr_valid_o=0 next cycle. Jump wins over gnt (pc takes target, not +1) and
//   over a simultaneous pop. Outstanding or same-cycle-granted response is marked
//   stale and dropped on rvalid (epoch bit); FSM still waits for it before re-requesting.
//  Jump while req=1, gnt=0: addr changes to target next cycle, req stays high.
//  Buffer full: no request issued; push never occurs when full (guaranteed by credit).
//  Push and pop same cycle: both occur; count unchanged.
//  rvalid outside WAIT: ignored.
// TESTING
//  Reset, gnt=1 always, rvalid 1 cycle after gnt, ready=1 -> addrs 0,1,2,...
//   instr_pc_o follows; one instruction per 2 cycles.
//  ready=0, BUF_DEPTH=2 -> two fetches (0,1) buffered, req drops to 0,
//   pc_o=2; ready=1 pops 0 then 1, fetch of 2 resumes.
//  Run to pc=255 -> next fetch addr 0, instr_pc_o shows 255 then 0.
//  jump_i=1,tgt=5'h1C in WAIT -> stale rvalid dropped (no valid), next req addr 0x1C.
//  jump with gnt same cycle at pc=7, tgt=3 -> pc_o=3 (not 8), fetch of 7 dropped.
//  halt_i=1 during WAIT -> response buffered, then req stays 0; halt_i=0 -> resumes at pc.
//  Assert rst_n=0 mid-WAIT -> all outputs to reset values immediately; restart at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter owner and instruction fetch front end.
// It issues one fetch at a time to instruction memory and keeps the returned
// words, each tagged with the address it came from, in a small FIFO that the
// decoder drains.
//
// Handshakes: imem_req_o/imem_gnt_i transfer a request on any rising edge where
// both are high. imem_rvalid_i returns one word for the single outstanding
// request. instr_valid_o/instr_ready_i pop the buffer head on any rising edge
// where both are high and no jump is taking place.
module pc_fetch_unit #(
  parameter int ADDR_W    = 8,
  parameter int INSTR_W   = 16,
  parameter int TGT_W     = 5,
  parameter int BUF_DEPTH = 2,
  parameter int RESET_PC  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               halt_i,
  input  logic               jump_i,
  input  logic [TGT_W-1:0]   jump_tgt_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  input  logic               instr_ready_i,
  output logic [ADDR_W-1:0]  pc_o
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  // Set when the outstanding response belongs to a flushed instruction stream.
  logic                stale_q, stale_d;

  logic [INSTR_W-1:0]  data_q [BUF_DEPTH];
  logic [ADDR_W-1:0]   addr_q [BUF_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;

  logic                req;
  logic                push;
  logic                pop;
  logic                credit_ok;
  logic [ADDR_W-1:0]   jump_pc;

  // In FETCH nothing is outstanding, so the only credit consumer is the buffer.
  assign credit_ok = (count_q < CNT_W'(BUF_DEPTH));
  assign jump_pc   = {{(ADDR_W-TGT_W){1'b0}}, jump_tgt_i};
  assign pop       = (count_q != '0) && instr_ready_i && !jump_i;

  // Next-state, PC update and request generation; jump overrides everything.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    stale_d    = stale_q;
    req        = 1'b0;
    push       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        req = credit_ok;
        if (req && imem_gnt_i) begin
          state_d    = ST_WAIT;
          pc_d       = pc_q + ADDR_W'(1);
          req_addr_d = pc_q;
          stale_d    = 1'b0;
        end else if (halt_i) begin
          state_d = ST_HALTED;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          push    = !stale_q;
          stale_d = 1'b0;
          state_d = halt_i ? ST_HALTED : ST_FETCH;
        end
      end
      ST_HALTED: begin
        if (!halt_i) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
    if (jump_i) begin
      pc_d = jump_pc;
      push = 1'b0;
      // Any request still in flight after this edge belongs to the old stream.
      if (state_d == ST_WAIT) stale_d = 1'b1;
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= ADDR_W'(RESET_PC);
      req_addr_q <= '0;
      stale_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      stale_q    <= stale_d;
    end
  end

  // Instruction buffer: push from memory, pop to decoder, flush on jump.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else if (jump_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= imem_rdata_i;
        addr_q[wr_ptr_q] <= req_addr_q;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign imem_req_o    = req;
  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = instr_valid_o ? data_q[rd_ptr_q] : '0;
  assign instr_pc_o    = instr_valid_o ? addr_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a small instruction-memory responder
// and an expected-address queue for the decoder side.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        halt_i;
  logic        jump_i;
  logic [4:0]  jump_tgt_i;
  logic        imem_req_o;
  logic [7:0]  imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [15:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [15:0] instr_o;
  logic [7:0]  instr_pc_o;
  logic        instr_ready_i;
  logic [7:0]  pc_o;

  int vec_cnt;
  int miscmp_cnt;
  int lat;
  int pend_cnt;
  logic [7:0] pend_addr;
  logic [7:0] exp_q[$];

  pc_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .halt_i        (halt_i),
    .jump_i        (jump_i),
    .jump_tgt_i    (jump_tgt_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
    .pc_o          (pc_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a word that encodes its own address.
  function automatic logic [15:0] mk(input logic [7:0] a);
    return {a ^ 8'h5A, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock: scoreboard the pop, advance, then drive the memory response.
  task automatic step();
    logic       fire;
    logic [7:0] a;
    logic [7:0] e;
    fire = imem_req_o && imem_gnt_i;
    a    = imem_addr_o;
    if (instr_valid_o && instr_ready_i && !jump_i) begin
      if (exp_q.size() == 0) begin
        check("sb_extra_pop", {24'd0, instr_pc_o}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", {24'd0, instr_pc_o}, {24'd0, e});
        check("sb_data", {16'd0, instr_o}, {16'd0, mk(e)});
      end
    end
    @(posedge clk);
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    if (fire) begin
      pend_cnt  = lat;
      pend_addr = a;
    end
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mk(pend_addr);
      end
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) step();
    check("sb_drain_left", exp_q.size(), 0);
  endtask

  // Asynchronous reset applied at a falling edge; outputs checked before any clock.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_pc", {24'd0, pc_o}, 32'd0);
    check("rst_req", {31'd0, imem_req_o}, 32'd0);
    check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    check("rst_instr", {16'd0, instr_o}, 32'd0);
    check("rst_instr_pc", {24'd0, instr_pc_o}, 32'd0);
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    jump_i        = 1'b0;
    jump_tgt_i    = '0;
    halt_i        = 1'b0;
    pend_cnt      = 0;
    lat           = 1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_cnt       = 0;
    miscmp_cnt    = 0;
    rst_n         = 1'b0;
    halt_i        = 1'b0;
    jump_i        = 1'b0;
    jump_tgt_i    = '0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    instr_ready_i = 1'b0;
    lat           = 1;
    pend_cnt      = 0;
    pend_addr     = '0;
    @(negedge clk);

    // Streaming with wrap: addresses 0..255 then 0,1.
    do_reset();
    imem_gnt_i    = 1'b1;
    instr_ready_i = 1'b1;
    check("idle_req", {31'd0, imem_req_o}, 32'd0);
    step();
    check("first_req", {31'd0, imem_req_o}, 32'd1);
    check("first_addr", {24'd0, imem_addr_o}, 32'd0);
    for (int i = 0; i < 258; i++) exp_q.push_back(8'(i));
    drain(1200);

    // Reset in the middle of a WAIT, then restart from 0.
    do_reset();
    step();
    step();
    check("midwait_pc", {24'd0, pc_o}, 32'd1);
    check("midwait_req", {31'd0, imem_req_o}, 32'd0);
    do_reset();
    step();
    check("restart_req", {31'd0, imem_req_o}, 32'd1);
    check("restart_addr", {24'd0, imem_addr_o}, 32'd0);

    // Decoder stalled: buffer fills with 0 and 1, then requests stop.
    do_reset();
    instr_ready_i = 1'b0;
    repeat (6) step();
    check("full_req", {31'd0, imem_req_o}, 32'd0);
    check("full_pc", {24'd0, pc_o}, 32'd2);
    check("full_valid", {31'd0, instr_valid_o}, 32'd1);
    check("full_head_pc", {24'd0, instr_pc_o}, 32'd0);
    check("full_head_data", {16'd0, instr_o}, {16'd0, mk(8'd0)});
    instr_ready_i = 1'b1;
    exp_q.push_back(8'd0);
    exp_q.push_back(8'd1);
    exp_q.push_back(8'd2);
    drain(20);

    // Jump during WAIT with a slow response: the old word is dropped.
    do_reset();
    instr_ready_i = 1'b1;
    lat = 2;
    step();
    step();
    jump_i     = 1'b1;
    jump_tgt_i = 5'h1C;
    step();
    jump_i = 1'b0;
    check("jw_pc", {24'd0, pc_o}, 32'h1C);
    check("jw_req_wait", {31'd0, imem_req_o}, 32'd0);
    check("jw_stale_rvalid", {31'd0, imem_rvalid_i}, 32'd1);
    step();
    check("jw_valid", {31'd0, instr_valid_o}, 32'd0);
    check("jw_req", {31'd0, imem_req_o}, 32'd1);
    check("jw_addr", {24'd0, imem_addr_o}, 32'h1C);
    lat = 1;
    exp_q.push_back(8'h1C);
    exp_q.push_back(8'h1D);
    drain(20);

    // Jump while requesting without grant, then jump with grant at pc=7.
    do_reset();
    imem_gnt_i    = 1'b0;
    instr_ready_i = 1'b1;
    step();
    jump_i     = 1'b1;
    jump_tgt_i = 5'd7;
    step();
    jump_i = 1'b0;
    check("jr_req", {31'd0, imem_req_o}, 32'd1);
    check("jr_addr", {24'd0, imem_addr_o}, 32'd7);
    step();
    check("hold_addr", {24'd0, imem_addr_o}, 32'd7);
    imem_gnt_i = 1'b1;
    jump_i     = 1'b1;
    jump_tgt_i = 5'd3;
    step();
    jump_i = 1'b0;
    check("jg_pc", {24'd0, pc_o}, 32'd3);
    step();
    check("jg_valid", {31'd0, instr_valid_o}, 32'd0);
    check("jg_addr", {24'd0, imem_addr_o}, 32'd3);
    exp_q.push_back(8'd3);
    exp_q.push_back(8'd4);
    drain(20);

    // Halt raised during WAIT: response still buffered, then fetch pauses.
    do_reset();
    instr_ready_i = 1'b0;
    step();
    step();
    halt_i = 1'b1;
    step();
    check("halt_valid", {31'd0, instr_valid_o}, 32'd1);
    check("halt_head_pc", {24'd0, instr_pc_o}, 32'd0);
    check("halt_req0", {31'd0, imem_req_o}, 32'd0);
    step();
    step();
    check("halt_req1", {31'd0, imem_req_o}, 32'd0);
    check("halt_pc", {24'd0, pc_o}, 32'd1);
    halt_i = 1'b0;
    step();
    check("resume_req", {31'd0, imem_req_o}, 32'd1);
    check("resume_addr", {24'd0, imem_addr_o}, 32'd1);
    instr_ready_i = 1'b1;
    exp_q.push_back(8'd0);
    exp_q.push_back(8'd1);
    exp_q.push_back(8'd2);
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
